// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types, opcodes and select encodings for the multicycle controller
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWR   = 4'd4,
        S_MEMWB   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_JAL     = 4'd9,
        S_JALRADR = 4'd10,
        S_BRANCH  = 4'd11,
        S_LUI     = 4'd12,
        S_AUIPC   = 4'd13,
        S_TRAP    = 4'd14
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] RES_IMM       = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    function automatic logic [2:0] imm_src_for_op(input logic [6:0] op);
        case (op)
            OP_STORE:         return IMM_S;
            OP_BRANCH:        return IMM_B;
            OP_JAL:           return IMM_J;
            OP_LUI, OP_AUIPC: return IMM_U;
            default:          return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder_ext.sv
// rtl/alu_decoder_ext.sv - ALUOp/funct to ALUControl decode with width-dependent legality
module alu_decoder_ext
    import multicycle_pkg::*;
#(
    parameter int ALUC_W = 3
) (
    input  logic [1:0]        alu_op_i,
    input  logic [2:0]        funct3_i,
    input  logic              funct7b5_i,
    input  logic              op5_i,
    output logic [ALUC_W-1:0] alu_control_o,
    output logic              illegal_o
);

    localparam bit WIDE = (ALUC_W >= 4);

    logic [3:0] ctl;
    logic       unused_ctl;

    always_comb begin
        ctl       = ALU_ADD;
        illegal_o = 1'b0;
        case (alu_op_i)
            ALUOP_ADD: ctl = ALU_ADD;
            ALUOP_SUB: ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    3'b000: ctl = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: begin
                        ctl       = ALU_SLL;
                        illegal_o = !op5_i && funct7b5_i;
                    end
                    3'b010: ctl = ALU_SLT;
                    3'b011: begin
                        ctl       = ALU_SLTU;
                        illegal_o = !WIDE;
                    end
                    3'b100: ctl = ALU_XOR;
                    3'b101: begin
                        ctl       = funct7b5_i ? ALU_SRA : ALU_SRL;
                        illegal_o = funct7b5_i && !WIDE;
                    end
                    3'b110: ctl = ALU_OR;
                    default: ctl = ALU_AND;
                endcase
            end
            default: ctl = ALU_ADD;
        endcase
        // Trapping encodings must not leak codes that do not fit a narrow ALU.
        if (illegal_o) begin
            ctl = ALU_ADD;
        end
    end

    assign alu_control_o = ctl[ALUC_W-1:0];
    assign unused_ctl    = ^ctl;

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Moore FSM sequencing RV32I instructions over a shared-memory datapath
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int ALUC_W  = 3,
    parameter bit EXT_OPS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              Zero,
    input  logic              Neg,
    input  logic              Carry,
    input  logic              Ovf,
    input  logic              MemReady,
    output logic              MemReq,
    output logic              MemWrite,
    output logic              AdrSrc,
    output logic              IRWrite,
    output logic              PCWrite,
    output logic              RegWrite,
    output logic [1:0]        ResultSrc,
    output logic [1:0]        ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [2:0]        ImmSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              IllegalInstr,
    output logic [3:0]        state_o
);

    state_e state_q, state_d;

    logic [1:0]        alu_op;
    logic [ALUC_W-1:0] dec_ctl;
    logic              dec_illegal;
    logic              instr_illegal;
    logic              taken;
    logic              mem_req, mem_write, ir_write, pc_write, reg_write, illegal;

    alu_decoder_ext #(.ALUC_W(ALUC_W)) u_alu_dec (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .funct7b5_i    (funct7b5),
        .op5_i         (op[5]),
        .alu_control_o (dec_ctl),
        .illegal_o     (dec_illegal)
    );

    // dec_illegal is meaningful here because DECODE drives the decoder in funct mode.
    always_comb begin
        instr_illegal = 1'b0;
        case (op)
            OP_LOAD, OP_STORE, OP_JAL: instr_illegal = 1'b0;
            OP_R, OP_I:                instr_illegal = dec_illegal;
            OP_BRANCH:                 instr_illegal = (funct3[2:1] == 2'b01) ||
                                                       (!EXT_OPS && funct3 != 3'b000);
            OP_JALR, OP_LUI, OP_AUIPC: instr_illegal = !EXT_OPS;
            default:                   instr_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (funct3)
            3'b000:  taken = Zero;
            3'b001:  taken = !Zero;
            3'b100:  taken = Neg ^ Ovf;
            3'b101:  taken = !(Neg ^ Ovf);
            3'b110:  taken = !Carry;
            3'b111:  taken = Carry;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        ImmSrc    = IMM_I;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_write  = MemReady;
                pc_write  = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = instr_illegal ? IMM_I : imm_src_for_op(op);
                alu_op  = ALUOP_FUNCT;
                if (instr_illegal) begin
                    state_d = S_TRAP;
                end else begin
                    case (op)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_I:              state_d = S_EXECI;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALRADR;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_STORE) ? IMM_S : IMM_I;
                state_d = (op == OP_STORE) ? S_MEMWR : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                AdrSrc    = 1'b1;
                if (MemReady) state_d = S_FETCH;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                ResultSrc = RES_DATA;
                state_d   = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_RD2;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
                state_d  = S_ALUWB;
            end
            S_JALRADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JAL;
            end
            S_BRANCH: begin
                ALUSrcA  = SRCA_RD1;
                ALUSrcB  = SRCB_RD2;
                alu_op   = ALUOP_SUB;
                pc_write = taken;
                state_d  = S_FETCH;
            end
            S_LUI: begin
                ImmSrc    = IMM_U;
                ResultSrc = RES_IMM;
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                state_d = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // The decoder runs in funct mode during DECODE only to judge legality; the ALU itself must add.
    assign ALUControl   = (state_q == S_DECODE) ? ALUC_W'(ALU_ADD) : dec_ctl;
    assign MemReq       = mem_req   && !reset;
    assign MemWrite     = mem_write && !reset;
    assign IRWrite      = ir_write  && !reset;
    assign PCWrite      = pc_write  && !reset;
    assign RegWrite     = reg_write && !reset;
    assign IllegalInstr = illegal   && !reset;
    assign state_o      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;
    import multicycle_pkg::*;

    localparam logic [6:0] T_LOAD   = 7'h03;
    localparam logic [6:0] T_STORE  = 7'h23;
    localparam logic [6:0] T_R      = 7'h33;
    localparam logic [6:0] T_I      = 7'h13;
    localparam logic [6:0] T_BRANCH = 7'h63;
    localparam logic [6:0] T_JAL    = 7'h6F;
    localparam logic [6:0] T_JALR   = 7'h67;
    localparam logic [6:0] T_LUI    = 7'h37;
    localparam logic [6:0] T_AUIPC  = 7'h17;
    localparam logic [18:0] RESET_OUT = 19'b000000_10_00_10_000_000_0;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       Zero = 1'b0, Neg = 1'b0, Carry = 1'b0, Ovf = 1'b0;
    logic       MemReady = 1'b0;
    logic       MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, IllegalInstr;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_o;
    logic [18:0] obs;

    int n_checks = 0;
    int n_fail = 0;

    multicycle_controller #(.ALUC_W(3), .EXT_OPS(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .Neg(Neg), .Carry(Carry), .Ovf(Ovf), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .IllegalInstr(IllegalInstr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, IllegalInstr};

    // Reference model (ALUC_W=3, EXT_OPS=1), written from the instruction-level rules.
    function automatic bit model_legal(input logic [6:0] o, input logic [2:0] f, input logic b);
        case (o)
            T_LOAD, T_STORE, T_JAL, T_JALR, T_LUI, T_AUIPC: return 1'b1;
            T_BRANCH: return !(f == 3'd2 || f == 3'd3);
            T_R:      return !(f == 3'd3) && !(f == 3'd5 && b);
            T_I:      return !(f == 3'd3) && !(f == 3'd5 && b) && !(f == 3'd1 && b);
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] model_alu(input bit is_r, input logic [2:0] f, input logic b);
        case (f)
            3'd0: return (is_r && b) ? 3'd1 : 3'd0;
            3'd1: return 3'd6;
            3'd2: return 3'd5;
            3'd4: return 3'd4;
            3'd5: return 3'd7;
            3'd6: return 3'd3;
            3'd7: return 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [18:0] model_out(input state_e s, input logic [6:0] o, input logic [2:0] f,
                                              input logic b, input logic rdy, input logic [3:0] flg);
        logic mreq = 0, mw = 0, adr = 0, irw = 0, pcw = 0, rw = 0, ill = 0;
        logic [1:0] res = 0, a = 0, bs = 0;
        logic [2:0] imm = 0, alu = 0;
        logic z, n, c, v;
        {z, n, c, v} = flg;
        case (s)
            S_FETCH:   begin mreq = 1; res = 2; bs = 2; irw = rdy; pcw = rdy; end
            S_DECODE: begin
                a = 1; bs = 1;
                if (model_legal(o, f, b)) begin
                    if (o == T_STORE) imm = 1;
                    else if (o == T_BRANCH) imm = 2;
                    else if (o == T_JAL) imm = 3;
                    else if (o == T_LUI || o == T_AUIPC) imm = 4;
                end
            end
            S_MEMADR:  begin a = 2; bs = 1; imm = (o == T_STORE) ? 3'd1 : 3'd0; end
            S_MEMREAD: begin mreq = 1; adr = 1; end
            S_MEMWR:   begin mreq = 1; mw = 1; adr = 1; end
            S_MEMWB:   begin rw = 1; res = 1; end
            S_EXECR:   begin a = 2; alu = model_alu(1'b1, f, b); end
            S_EXECI:   begin a = 2; bs = 1; alu = model_alu(1'b0, f, b); end
            S_ALUWB:   rw = 1;
            S_JAL:     begin a = 1; bs = 2; pcw = 1; end
            S_JALRADR: begin a = 2; bs = 1; end
            S_BRANCH: begin
                a = 2; alu = 1;
                case (f)
                    3'd0: pcw = z;
                    3'd1: pcw = !z;
                    3'd4: pcw = n ^ v;
                    3'd5: pcw = !(n ^ v);
                    3'd6: pcw = !c;
                    3'd7: pcw = c;
                    default: pcw = 0;
                endcase
            end
            S_LUI:     begin imm = 4; res = 3; rw = 1; end
            S_AUIPC:   begin a = 1; bs = 1; imm = 4; end
            S_TRAP:    ill = 1;
            default:   ill = 0;
        endcase
        return {mreq, mw, adr, irw, pcw, rw, res, a, bs, imm, alu, ill};
    endfunction

    task automatic step(input logic rdy);
        @(posedge clk);
        #1;
        MemReady = rdy;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b1);
            n_checks++;
            if ({state_o, obs} !== {4'd0, RESET_OUT}) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got state=%0d out=%h, expected state=0 out=%h",
                         i, state_o, obs, RESET_OUT);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        n_checks++;
        if ({state_o, MemReq, IRWrite, PCWrite} !== {4'd0, 3'b100}) begin
            n_fail++;
            $display("FAIL reset_release: got state=%0d req/ir/pc=%b%b%b, expected 0 100",
                     state_o, MemReq, IRWrite, PCWrite);
        end
        step(1'b0);
        n_checks++;
        if ({state_o, MemReq} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL fetch_wait: got state=%0d req=%b, expected 0 1", state_o, MemReq);
        end
    endtask

    task automatic test_lw();
        state_e exp_s [5] = '{S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB};
        op = T_LOAD; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            n_checks++;
            if (state_o !== exp_s[i] || RegWrite !== (i == 4)) begin
                n_fail++;
                $display("FAIL lw_seq cycle %0d: got state=%0d rw=%b, expected state=%0d rw=%b",
                         i, state_o, RegWrite, exp_s[i], (i == 4));
            end
            if (i == 4) begin
                n_checks++;
                if (ResultSrc !== 2'b01) begin
                    n_fail++;
                    $display("FAIL lw_resultsrc: got %b expected 01", ResultSrc);
                end
            end
        end
    endtask

    task automatic test_sw_wait();
        state_e exp_s [3] = '{S_FETCH, S_DECODE, S_MEMADR};
        int wr_cycles = 0;
        op = T_STORE; funct3 = 3'b010; funct7b5 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            n_checks++;
            if (state_o !== exp_s[i] || MemWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL sw_pre cycle %0d: got state=%0d mw=%b, expected state=%0d mw=0",
                         i, state_o, MemWrite, exp_s[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(i == 3);
            if (state_o == S_MEMWR && MemWrite && MemReq && AdrSrc) wr_cycles++;
        end
        n_checks++;
        if (wr_cycles != 4) begin
            n_fail++;
            $display("FAIL sw_wait_cycles: got %0d write cycles, expected 4", wr_cycles);
        end
        step(1'b0);
        n_checks++;
        if (state_o !== S_FETCH || MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL sw_return: got state=%0d mw=%b, expected state=0 mw=0", state_o, MemWrite);
        end
    endtask

    task automatic test_branch();
        logic [7:0] tbl [8] = '{
            {3'b000, 4'b1000, 1'b1}, {3'b001, 4'b1000, 1'b0},
            {3'b100, 4'b0100, 1'b1}, {3'b100, 4'b0101, 1'b0},
            {3'b101, 4'b0000, 1'b1}, {3'b110, 4'b0000, 1'b1},
            {3'b111, 4'b0010, 1'b1}, {3'b111, 4'b1000, 1'b0}};
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t = tbl[i];
            op = T_BRANCH; funct3 = t[7:5];
            {Zero, Neg, Carry, Ovf} = t[4:1];
            step(1'b1);
            step(1'b1);
            step(1'b1);
            n_checks++;
            if (state_o !== S_BRANCH || PCWrite !== t[0] || ALUControl !== 3'd1) begin
                n_fail++;
                $display("FAIL branch case %0d: got state=%0d pcw=%b alu=%0d, expected state=%0d pcw=%b alu=1",
                         i, state_o, PCWrite, ALUControl, S_BRANCH, t[0]);
            end
        end
    endtask

    task automatic test_jalr();
        state_e exp_s [5] = '{S_FETCH, S_DECODE, S_JALRADR, S_JAL, S_ALUWB};
        logic [4:0] pcw_exp = 5'b01001;
        logic [4:0] rw_exp  = 5'b10000;
        op = T_JALR; funct3 = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            n_checks++;
            if (state_o !== exp_s[i] || PCWrite !== pcw_exp[i] || RegWrite !== rw_exp[i]) begin
                n_fail++;
                $display("FAIL jalr cycle %0d: got state=%0d pcw=%b rw=%b, expected state=%0d pcw=%b rw=%b",
                         i, state_o, PCWrite, RegWrite, exp_s[i], pcw_exp[i], rw_exp[i]);
            end
        end
    endtask

    task automatic test_trap();
        for (int j = 0; j < 2; j++) begin
            if (j == 0) begin
                op = 7'h7F; funct3 = 3'($urandom); funct7b5 = 1'b0;
            end else begin
                op = T_R; funct3 = 3'b101; funct7b5 = 1'b1;
            end
            step(1'b1);
            step(1'b1);
            n_checks++;
            if (state_o !== S_DECODE || IllegalInstr !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_decode %0d: got state=%0d ill=%b, expected state=1 ill=0", j, state_o, IllegalInstr);
            end
            step(1'b1);
            n_checks++;
            if (state_o !== S_TRAP || IllegalInstr !== 1'b1 || RegWrite !== 1'b0 ||
                MemWrite !== 1'b0 || PCWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_pulse %0d: got state=%0d ill/rw/mw/pcw=%b%b%b%b, expected state=%0d 1000",
                         j, state_o, IllegalInstr, RegWrite, MemWrite, PCWrite, S_TRAP);
            end
            step(1'b0);
            n_checks++;
            if (state_o !== S_FETCH || IllegalInstr !== 1'b0) begin
                n_fail++;
                $display("FAIL trap_end %0d: got state=%0d ill=%b, expected state=0 ill=0", j, state_o, IllegalInstr);
            end
        end
        funct7b5 = 1'b0;
    endtask

    task automatic test_reset_midwait();
        op = T_LOAD; funct3 = 3'b010;
        step(1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        n_checks++;
        if (state_o !== S_MEMREAD || MemReq !== 1'b1) begin
            n_fail++;
            $display("FAIL midwait_pre: got state=%0d req=%b, expected state=%0d req=1", state_o, MemReq, S_MEMREAD);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({state_o, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, IllegalInstr} !== 10'd0) begin
            n_fail++;
            $display("FAIL midwait_reset: got state=%0d enables=%b%b%b%b%b%b, expected state=0 enables=000000",
                     state_o, MemReq, MemWrite, IRWrite, PCWrite, RegWrite, IllegalInstr);
        end
        step(1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        n_checks++;
        if ({state_o, MemReq, IRWrite} !== {4'd0, 2'b10}) begin
            n_fail++;
            $display("FAIL midwait_release: got state=%0d req=%b ir=%b, expected 0 1 0", state_o, MemReq, IRWrite);
        end
        step(1'b0);
        step(1'b1);
        n_checks++;
        if ({state_o, IRWrite} !== {4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL midwait_fetch: got state=%0d ir=%b, expected 0 1", state_o, IRWrite);
        end
        step(1'b1);
        n_checks++;
        if (state_o !== S_DECODE || MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL midwait_advance: got state=%0d mw=%b, expected state=%0d mw=0", state_o, MemWrite, S_DECODE);
        end
        for (int i = 0; i < 3; i++) step(1'b1);
    endtask

    task automatic test_random();
        logic [6:0] ops [9] = '{T_LOAD, T_STORE, T_R, T_I, T_BRANCH, T_JAL, T_JALR, T_LUI, T_AUIPC};
        state_e path[$];
        state_e s;
        logic [6:0] o;
        logic [2:0] f;
        logic b, rdy;
        logic [3:0] flg;
        logic [18:0] exp_o;
        int k, idx, waits;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            o = (k < 9) ? ops[k] : 7'($urandom);
            f = 3'($urandom);
            b = 1'($urandom);
            op = o; funct3 = f; funct7b5 = b;
            path = '{S_FETCH, S_DECODE};
            if (!model_legal(o, f, b)) path.push_back(S_TRAP);
            else if (o == T_LOAD)   path = {path, S_MEMADR, S_MEMREAD, S_MEMWB};
            else if (o == T_STORE)  path = {path, S_MEMADR, S_MEMWR};
            else if (o == T_R)      path = {path, S_EXECR, S_ALUWB};
            else if (o == T_I)      path = {path, S_EXECI, S_ALUWB};
            else if (o == T_JAL)    path = {path, S_JAL, S_ALUWB};
            else if (o == T_JALR)   path = {path, S_JALRADR, S_JAL, S_ALUWB};
            else if (o == T_BRANCH) path.push_back(S_BRANCH);
            else if (o == T_LUI)    path.push_back(S_LUI);
            else                    path = {path, S_AUIPC, S_ALUWB};
            idx = 0;
            waits = 0;
            while (idx < path.size()) begin
                s = path[idx];
                rdy = (waits >= 4) ? 1'b1 : 1'($urandom);
                flg = 4'($urandom);
                @(posedge clk);
                #1;
                MemReady = rdy;
                {Zero, Neg, Carry, Ovf} = flg;
                #1;
                exp_o = model_out(s, o, f, b, rdy, flg);
                n_checks++;
                if ({state_o, obs} !== {s, exp_o}) begin
                    n_fail++;
                    $display("FAIL random instr %0d op=%h f3=%0d f7b5=%b: got state=%0d out=%h, expected state=%0d out=%h",
                             n, o, f, b, state_o, obs, s, exp_o);
                end
                if ((s == S_FETCH || s == S_MEMREAD || s == S_MEMWR) && !rdy) begin
                    waits++;
                end else begin
                    idx++;
                    waits = 0;
                end
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jalr();
        test_trap();
        test_reset_midwait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle RV32I core. Successor to the single-cycle decoder.
- Sequences each instruction through a Moore FSM: Fetch, Decode, Execute, Memory and Writeback.
- Adds lui/auipc/jalr, the full branch set, a variable-latency memory handshake, illegal-instruction trapping and a width-parametrised ALU control.
- Sits between the instruction register/ALU flags and the shared-memory datapath.

Parameters:
- ALUC_W, 3, ALUControl width. Legal values are 3 or 4. At 4, sra and sltu are legal; at 3 they trap.
- EXT_OPS, 1. At 1, lui/auipc/jalr and bne/blt/bge/bltu/bgeu are legal. At 0, only lw/sw/R/I/beq/jal are legal; everything else traps.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high; one clock domain
- op  in  7  IR[6:0], stable from Decode until next Fetch
- funct3  in  3  IR[14:12]
- funct7b5  in  1  IR[30]
- Zero, Neg, Carry, Ovf  in  1 each  ALU flags of the current-cycle result
- MemReady  in  1  memory completes the request this cycle
- MemReq  out  1  memory access request
- MemWrite  out  1  write strobe
- AdrSrc  out  1  address select: 0=PC, 1=ALUOut
- IRWrite  out  1  latch IR and OldPC
- PCWrite  out  1  PC load enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=ImmExt
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rd1
- ALUSrcB  out  2  00=rd2, 01=ImmExt, 10=const 4
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- ALUControl  out  ALUC_W  0=add, 1=sub, 2=and, 3=or, 4=xor, 5=slt, 6=sll, 7=srl, 8=sra, 9=sltu
- IllegalInstr  out  1  one-cycle trap pulse
- state_o  out  4  current state, for debug

Behaviour:
- States and successors:
  - FETCH: next DECODE, on MemReady only.
  - DECODE: lw/sw→MEMADR; R→EXECR; I→EXECI; jal→JAL; jalr→JALRADR; B→BRANCH; lui→LUI; auipc→AUIPC; illegal→TRAP.
  - MEMADR: lw→MEMREAD; sw→MEMWR.
  - MEMREAD: next MEMWB, on MemReady.
  - MEMWR: next FETCH, on MemReady.
  - EXECR, EXECI, AUIPC: next ALUWB.
  - JALRADR: next JAL.
  - JAL: next ALUWB.
  - MEMWB, ALUWB, BRANCH, LUI, TRAP: next FETCH.
- Outputs are Moore, except that PCWrite/IRWrite are gated by MemReady and the branch decision.
- FETCH: MemReq=1, AdrSrc=0, SrcA=00, SrcB=10, ALUControl=add, ResultSrc=10. IRWrite=PCWrite=MemReady. While MemReady=0, the state holds and no enables fire.
- DECODE: SrcA=01, SrcB=01, add; ImmSrc follows op. This precomputes OldPC+imm into ALUOut.
- MEMADR: SrcA=10, SrcB=01, add; ImmSrc I (lw) or S (sw).
- MEMREAD: MemReq=1, AdrSrc=1; hold until MemReady.
- MEMWR: MemReq=1, MemWrite=1, AdrSrc=1; MemWrite is held stable across wait cycles.
- MEMWB: RegWrite=1, ResultSrc=01.
- EXECR/EXECI: SrcA=10, SrcB=00 (R) or 01 (I); ALUControl comes from the ALU sub-decoder.
- ALUWB: RegWrite=1, ResultSrc=00.
- JAL: SrcA=01, SrcB=10, add, ResultSrc=00, PCWrite=1. PC<=ALUOut (target); ALUOut<=OldPC+4.
- JALRADR: SrcA=10, SrcB=01, ImmSrc I, add. The datapath clears bit 0 of the target.
- BRANCH: SrcA=10, SrcB=00, sub, ResultSrc=00. PCWrite=taken, where:
  - beq: taken=Zero
  - bne: taken=!Zero
  - blt: taken=Neg^Ovf
  - bge: taken=!(Neg^Ovf)
  - bltu: taken=!Carry
  - bgeu: taken=Carry
- LUI: ImmSrc U, ResultSrc=11, RegWrite=1.
- AUIPC: SrcA=01, SrcB=01, ImmSrc U, add.
- ALU sub-decoder:
  - add/sub: sub only when R-type with funct7b5=1.
  - srl/sra: selected by funct7b5.
  - slli/srli/srai with an illegal funct7 trap.
- Illegal cases: unknown op; branch funct3 010 or 011; sra/sltu/sltiu/srai at ALUC_W=3; ext ops at EXT_OPS=0.
- TRAP: IllegalInstr=1 for exactly one cycle, all write enables 0, then FETCH. The PC has already advanced past the faulting instruction.
- Reset:
  - state<=FETCH asynchronously.
  - While reset=1: MemReq, MemWrite, IRWrite, PCWrite, RegWrite and IllegalInstr are forced 0.
  - The other outputs take FETCH values; state_o=0.
  - Reset during a memory wait abandons the access; no stale write occurs after deassertion.
  - The first request is issued in the first cycle after deassertion.
- Every write enable is 0 in every state not listed above.
- Don't-care selects are driven to 0, never X.

Decomposition:
- Package multicycle_pkg holds:
  - the state enum (4-bit, FETCH=0);
  - opcode constants;
  - ResultSrc, ALUSrcA, ALUSrcB and ImmSrc encodings;
  - ALUControl codes;
  - ALUOp codes: 00 add, 01 sub, 10 funct.
- Sub-module alu_decoder_ext: combinational; inputs ALUOp, funct3, funct7b5, op[5]; outputs ALUControl and an illegal flag. Parametrised by ALUC_W.

Test Plan:
- lw with MemReady=1 in both memory states → FETCH, DECODE, MEMADR, MEMREAD, MEMWB. RegWrite=1 only in the 5th cycle, with ResultSrc=01.
- sw with MemReady held 0 for 3 cycles in MEMWR → MemWrite=1 and MemReq=1 for 4 cycles. Return to FETCH on the cycle after MemReady=1.
- blt (funct3=100) with Neg=1, Ovf=0 → PCWrite=1 in BRANCH. With Neg=1, Ovf=1 → PCWrite=0. The bgeu sequence with Carry=1 → PCWrite=1.
- jalr (op 1100111) → DECODE, JALRADR, JAL, ALUWB. PCWrite=1 only in JAL and FETCH; RegWrite=1 in ALUWB.
- op=0x7F, plus sra at ALUC_W=3 → TRAP. IllegalInstr pulses exactly 1 cycle, with RegWrite=MemWrite=0, then FETCH.
- reset asserted in MEMREAD mid-wait → state_o=0 immediately and all enables 0. After release, MemReq=1 and the state advances only on MemReady.
